// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter onto one shared memory bus.
// Optional grant watchdog: define MEM_ARB_TIMEOUT_EN.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   mN_valid/instr/addr/wdata/wstrb   requester N request (N=0,1)
//   mN_ready/rdata       requester N completion and read data
//   s_valid/instr/addr/wdata/wstrb    shared memory request
//   s_ready/rdata        shared memory completion and read data
//   grant_id             last or current granted requester
//   timeout_err          one-cycle pulse on forced completion
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant_id,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t state;
  logic   gid_q;

  logic        gnt0;
  logic        gnt1;
  logic        g_valid;
  logic        done;
  logic        tmo;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  assign gnt0     = (state == GNT0);
  assign gnt1     = (state == GNT1);
  assign grant_id = gid_q;

  always_comb begin
    g_valid = 1'b0;
    unique case (1'b1)
      gnt0:    g_valid = m0_valid;
      gnt1:    g_valid = m1_valid;
      default: g_valid = 1'b0;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
    $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] cnt;

  // Forced completion once the grant has waited the full budget.
  assign tmo = g_valid && (cnt == CW'(TIMEOUT_CYCLES));
  assign timeout_err = tmo;
`else
  logic unused_tmo;

  assign unused_tmo  = (TIMEOUT_CYCLES == 0);
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    s_valid = 1'b0;
    s_instr = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    unique case (1'b1)
      gnt0: begin
        s_valid = m0_valid & ~tmo;
        s_instr = m0_instr;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
      end
      gnt1: begin
        s_valid = m1_valid & ~tmo;
        s_instr = m1_instr;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
      end
      default: ;
    endcase
  end

  assign done      = s_valid & s_ready;
  assign rsp_ready = done | tmo;
  assign rsp_data  = tmo ? 32'hDEAD_BEEF : s_rdata;

  assign m0_ready = gnt0 & rsp_ready;
  assign m1_ready = gnt1 & rsp_ready;
  assign m0_rdata = gnt0 ? rsp_data : '0;
  assign m1_rdata = gnt1 ? rsp_data : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      gid_q <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
          // On contention the requester not served last wins.
          if (m0_valid && m1_valid) begin
            state <= gid_q ? GNT0 : GNT1;
            gid_q <= ~gid_q;
          end else if (m0_valid) begin
            state <= GNT0;
            gid_q <= 1'b0;
          end else if (m1_valid) begin
            state <= GNT1;
            gid_q <= 1'b1;
          end
        end
        GNT0, GNT1: begin
`ifdef MEM_ARB_TIMEOUT_EN
          if (!s_ready) cnt <= cnt + 1'b1;
`endif
          // Abort, completion or forced completion all end the grant.
          if (!g_valid || done || tmo) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter.
// Directed scenarios plus randomized traffic against a reference model.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_instr;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_ready;
  logic [31:0] m0_rdata;
  logic        m1_valid, m1_instr;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        grant_id, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: manual mode or auto mode with random latency.
  logic        man_mode  = 1'b1;
  logic        man_ready = 1'b0;
  logic [31:0] man_rdata = '0;
  int          lat       = 0;
  int          lat_max   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_valid && s_ready) lat <= int'($urandom_range(0, lat_max));
    else if (s_valid && lat > 0) lat <= lat - 1;
  end

  assign s_ready = man_mode ? man_ready : (s_valid && lat == 0);
  assign s_rdata = man_mode ? man_rdata : (s_addr ^ 32'hC0DE_0000);

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  task automatic idle_inputs;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    man_ready = 0; man_rdata = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    idle_inputs();
    resetn = 0;
    m0_valid = 1;
    m1_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_s_valid: got %b exp 0", s_valid); end
    n_tests++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL rst_grant_id: got %b exp 1", grant_id); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b exp 0", timeout_err); end
    n_tests++; if ({m0_ready, m1_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b exp 00", {m0_ready, m1_ready}); end
    n_tests++; if (s_addr !== 32'h0) begin n_fail++; $display("FAIL rst_s_addr: got %h exp 0", s_addr); end
    @(posedge clk);
    #1 resetn = 1; m0_valid = 0; m1_valid = 0;
  endtask

  task automatic test_single_read;
    do_reset();
    man_mode = 1;
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 0;
    @(negedge clk);
    n_tests++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rd_idle_s_valid: got %b exp 0", s_valid); end
    next_cyc();
    @(negedge clk);
    n_tests++; if ({s_valid, s_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL rd_req: got %b/%h exp 1/100", s_valid, s_addr); end
    n_tests++; if ({grant_id, m0_ready} !== 2'b00) begin n_fail++; $display("FAIL rd_gid_rdy: got %b exp 00", {grant_id, m0_ready}); end
    next_cyc();
    man_ready = 1; man_rdata = 32'h1234_5678;
    @(negedge clk);
    n_tests++; if ({m0_ready, m0_rdata} !== {1'b1, 32'h1234_5678}) begin n_fail++; $display("FAIL rd_resp: got %b/%h exp 1/12345678", m0_ready, m0_rdata); end
    next_cyc();
    man_ready = 0; m0_valid = 0;
    @(negedge clk);
    n_tests++; if ({m0_ready, s_valid, grant_id} !== 3'b000) begin n_fail++; $display("FAIL rd_after: got %b exp 000", {m0_ready, s_valid, grant_id}); end
  endtask

  task automatic test_contention;
    logic [3:0] exp_v [4];
    logic r0, r1;
    exp_v = '{4'b0001, 4'b1100, 4'b0000, 4'b1011};
    do_reset();
    man_mode = 0; lat_max = 0;
    m0_valid = 1; m0_addr = 32'h10;
    m1_valid = 1; m1_addr = 32'h14;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r0 = m0_ready; r1 = m1_ready;
      n_tests++;
      if ({s_valid, m0_ready, m1_ready, grant_id} !== exp_v[i]) begin
        n_fail++;
        $display("FAIL contention_c%0d: got %b exp %b", i, {s_valid, m0_ready, m1_ready, grant_id}, exp_v[i]);
      end
      next_cyc();
      if (r0) m0_valid = 0;
      if (r1) m1_valid = 0;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    int k, last_c, idx;
    k = 0; last_c = 0;
    do_reset();
    man_mode = 0; lat_max = 0;
    m0_valid = 1; m1_valid = 1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        idx = m1_ready ? 1 : 0;
        n_tests++;
        if (idx != k % 2 || grant_id !== 1'(k % 2)) begin
          n_fail++;
          $display("FAIL alt_%0d: got req %0d gid %b exp %0d", k, idx, grant_id, k % 2);
        end
        if (k > 0) begin
          n_tests++;
          if (c - last_c != 2) begin n_fail++; $display("FAIL alt_gap_%0d: got %0d exp 2", k, c - last_c); end
        end
        last_c = c;
        k++;
      end
      next_cyc();
    end
    n_tests++; if (k != 6) begin n_fail++; $display("FAIL alt_count: got %0d exp 6", k); end
    idle_inputs();
  endtask

  task automatic test_write_m1;
    do_reset();
    man_mode = 1;
    m1_valid = 1; m1_addr = 32'h20; m1_wdata = 32'hA5A5; m1_wstrb = 4'b0011;
    @(negedge clk);
    n_tests++; if ({s_valid, s_addr, s_wstrb} !== 37'h0) begin n_fail++; $display("FAIL wr_idle_zero: got %b/%h/%b exp 0", s_valid, s_addr, s_wstrb); end
    next_cyc();
    m0_valid = 1; m0_addr = 32'h40; m0_instr = 1;
    @(negedge clk);
    n_tests++; if ({s_valid, s_addr, s_wdata, s_wstrb} !== {1'b1, 32'h20, 32'hA5A5, 4'b0011}) begin n_fail++; $display("FAIL wr_bus: got %b/%h/%h/%b exp 1/20/a5a5/0011", s_valid, s_addr, s_wdata, s_wstrb); end
    n_tests++; if ({m0_ready, grant_id} !== 2'b01) begin n_fail++; $display("FAIL wr_hold_m0: got %b exp 01", {m0_ready, grant_id}); end
    next_cyc();
    man_ready = 1; man_rdata = 32'h55;
    @(negedge clk);
    n_tests++; if ({m1_ready, m0_ready, m1_rdata, m0_rdata} !== {2'b10, 32'h55, 32'h0}) begin n_fail++; $display("FAIL wr_resp: got %b%b/%h/%h exp 10/55/0", m1_ready, m0_ready, m1_rdata, m0_rdata); end
    next_cyc();
    man_ready = 0; m1_valid = 0;
    @(negedge clk);
    n_tests++; if ({s_valid, grant_id} !== 2'b01) begin n_fail++; $display("FAIL wr_gap: got %b exp 01", {s_valid, grant_id}); end
    next_cyc();
    @(negedge clk);
    n_tests++; if ({s_valid, s_instr, s_addr, grant_id} !== {2'b11, 32'h40, 1'b0}) begin n_fail++; $display("FAIL wr_m0_kept: got %b%b/%h/%b exp 11/40/0", s_valid, s_instr, s_addr, grant_id); end
    next_cyc();
    man_ready = 1;
    @(negedge clk);
    n_tests++; if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL wr_m0_done: got %b exp 1", m0_ready); end
    next_cyc();
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    man_mode = 1;
    m0_valid = 1; m0_addr = 32'h300;
    next_cyc();
    @(negedge clk);
    n_tests++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL rm_granted: got %b exp 1", s_valid); end
    next_cyc();
    resetn = 0;
    @(negedge clk);
    n_tests++; if (m0_ready !== 1'b0) begin n_fail++; $display("FAIL rm_no_ready_a: got %b exp 0", m0_ready); end
    next_cyc();
    resetn = 1;
    @(negedge clk);
    n_tests++; if ({s_valid, m0_ready, grant_id} !== 3'b001) begin n_fail++; $display("FAIL rm_after: got %b exp 001", {s_valid, m0_ready, grant_id}); end
    next_cyc();
    idle_inputs();
    next_cyc();
  endtask

  task automatic test_timeout;
    do_reset();
    man_mode = 1;
    m0_valid = 1; m0_addr = 32'h500;
    next_cyc();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int g = 1; g <= 4; g++) begin
      @(negedge clk);
      n_tests++; if ({s_valid, m0_ready, timeout_err} !== 3'b100) begin n_fail++; $display("FAIL tmo_wait_%0d: got %b exp 100", g, {s_valid, m0_ready, timeout_err}); end
      next_cyc();
    end
    @(negedge clk);
    n_tests++; if ({s_valid, m0_ready, timeout_err} !== 3'b011) begin n_fail++; $display("FAIL tmo_fire: got %b exp 011", {s_valid, m0_ready, timeout_err}); end
    n_tests++; if (m0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tmo_rdata: got %h exp deadbeef", m0_rdata); end
    next_cyc();
    m0_valid = 0;
    @(negedge clk);
    n_tests++; if ({s_valid, m0_ready, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL tmo_idle: got %b exp 000", {s_valid, m0_ready, timeout_err}); end
`else
    for (int g = 1; g <= 20; g++) begin
      @(negedge clk);
      n_tests++; if ({s_valid, m0_ready, timeout_err} !== 3'b100) begin n_fail++; $display("FAIL hold_%0d: got %b exp 100", g, {s_valid, m0_ready, timeout_err}); end
      next_cyc();
    end
    man_ready = 1;
    @(negedge clk);
    n_tests++; if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL hold_done: got %b exp 1", m0_ready); end
`endif
    next_cyc();
    idle_inputs();
  endtask

  task automatic step_master(
    input  logic        seen,
    inout  logic        v,
    inout  logic        ins,
    inout  logic [31:0] a,
    inout  logic [31:0] d,
    inout  logic [3:0]  s
  );
    if (v && seen) v = 0;
    else if (v && $urandom_range(0, 15) == 0) v = 0;
    else if (!v && $urandom_range(0, 2) == 0) begin
      v = 1; ins = 1'($urandom_range(0, 1));
      a = $urandom; d = $urandom; s = 4'($urandom_range(0, 15));
    end
  endtask

  // Transaction-level model: who owns the bus and who was served last.
  task automatic test_random;
    int owner, last;
    logic r0, r1, ev;
    logic [69:0] exp_bus;
    logic [65:0] exp_rsp;
    owner = -1; last = 1;
    do_reset();
    man_mode = 0; lat_max = 3;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      exp_bus = '0;
      ev = 0;
      if (owner == 0) begin
        ev = m0_valid;
        exp_bus = {m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb};
      end else if (owner == 1) begin
        ev = m1_valid;
        exp_bus = {m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb};
      end
      exp_rsp = {owner == 0 && ev && s_ready, owner == 1 && ev && s_ready,
                 owner == 0 ? s_rdata : 32'h0, owner == 1 ? s_rdata : 32'h0};
      n_tests++;
      if ({s_valid, s_instr, s_addr, s_wdata, s_wstrb} !== exp_bus) begin
        n_fail++;
        $display("FAIL rnd_bus c%0d: got %h exp %h", c, {s_valid, s_instr, s_addr, s_wdata, s_wstrb}, exp_bus);
      end
      n_tests++;
      if ({m0_ready, m1_ready, m0_rdata, m1_rdata} !== exp_rsp) begin
        n_fail++;
        $display("FAIL rnd_rsp c%0d: got %h exp %h", c, {m0_ready, m1_ready, m0_rdata, m1_rdata}, exp_rsp);
      end
      n_tests++;
      if (grant_id !== 1'(last)) begin
        n_fail++;
        $display("FAIL rnd_gid c%0d: got %b exp %0d", c, grant_id, last);
      end
      if (owner < 0) begin
        if (m0_valid && m1_valid) owner = 1 - last;
        else if (m0_valid) owner = 0;
        else if (m1_valid) owner = 1;
        if (owner >= 0) last = owner;
      end else if (!ev || s_ready) begin
        owner = -1;
      end
      r0 = m0_ready; r1 = m1_ready;
      next_cyc();
      step_master(r0, m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb);
      step_master(r1, m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb);
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_write_m1();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
